// File: rtl/coa_pkg.sv
// Shared constants for the destination-select / writeback path.
// Register indexing and destination-type encodings used across the datapath.
package coa_pkg;

    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS  = 4;

    typedef enum logic [1:0] {
        DST_RIN1   = 2'b00,
        DST_RESULT = 2'b01,
        DST_D      = 2'b10
    } dst_type_e;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_queue.sv
// In-order write queue of {dst,data} pairs feeding the register file.
// Entries are exported in age order (index 0 = oldest) so forwarding needs no pointer math.
module wb_queue
    import coa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  reg_idx_t                      push_dst,
    input  logic [DATA_W-1:0]             push_data,
    output logic [$clog2(DEPTH):0]        pending,
    output reg_idx_t                      head_dst,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH*REG_IDX_W-1:0]    ent_dst,
    output logic [DEPTH*DATA_W-1:0]       ent_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_idx_t            dst_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && (pending != CNT_W'(DEPTH));
    assign do_pop  = pop && (pending != '0);

    // Occupancy is a dedicated counter so full and empty never alias when pointers meet.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            pending <= pending + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            dst_mem[wr_ptr]  <= push_dst;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_dst  = dst_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        ent_valid = '0;
        ent_dst   = '0;
        ent_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]                         = CNT_W'(i) < pending;
            ent_dst[i*REG_IDX_W +: REG_IDX_W]    = dst_mem[rd_ptr + PTR_W'(i)];
            ent_data[i*DATA_W +: DATA_W]         = data_mem[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/dst_writeback_regfile.sv
// Writeback end of the destination-select path: queued writes, 4-entry regfile,
// and two forwarded read ports that always return the newest value for an index.
module dst_writeback_regfile
    import coa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [REG_IDX_W-1:0]   wr_dst,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   commit_en,
    input  logic [REG_IDX_W-1:0]   rd_addr1,
    input  logic [REG_IDX_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   rd_fwd1,
    output logic                   rd_fwd2,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic                       push;
    logic                       pop;
    reg_idx_t                   head_dst;
    logic [DATA_W-1:0]          head_data;
    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH*REG_IDX_W-1:0] ent_dst;
    logic [DEPTH*DATA_W-1:0]    ent_data;

    // Ready depends only on occupancy, so a full queue refuses a push even while it pops.
    assign wr_ready = (pending != CNT_W'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = commit_en && (pending != '0);

    wb_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_dst  (wr_dst),
        .push_data (wr_data),
        .pending   (pending),
        .head_dst  (head_dst),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_dst   (ent_dst),
        .ent_data  (ent_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (pop) begin
            regs[head_dst] <= head_data;
        end
    end

    // Walk oldest to youngest so a younger match overrides an older one.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        rd_fwd1  = 1'b0;
        rd_fwd2  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_dst[i*REG_IDX_W +: REG_IDX_W] == rd_addr1)) begin
                rd_data1 = ent_data[i*DATA_W +: DATA_W];
                rd_fwd1  = 1'b1;
            end
            if (ent_valid[i] && (ent_dst[i*REG_IDX_W +: REG_IDX_W] == rd_addr2)) begin
                rd_data2 = ent_data[i*DATA_W +: DATA_W];
                rd_fwd2  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dst_writeback_regfile.sv
// Bench for dst_writeback_regfile: directed scenarios plus randomized traffic
// compared against a queue-and-array reference model.
module tb_dst_writeback_regfile;

    localparam int DEPTH = 2;

    typedef struct {
        logic [1:0] dst;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_dst = '0;
    logic [7:0] wr_data = '0;
    logic       commit_en = 1'b0;
    logic [1:0] rd_addr1 = '0;
    logic [1:0] rd_addr2 = '0;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic       rd_fwd1;
    logic       rd_fwd2;
    logic [1:0] pending;

    int   total = 0;
    int   bad = 0;
    ent_t mq[$];
    logic [7:0] mregs [4];

    dst_writeback_regfile #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .commit_en (commit_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_fwd1   (rd_fwd1),
        .rd_fwd2   (rd_fwd2),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model decides from the pre-edge state like the DUT does.
    task automatic step(input bit wv, input logic [1:0] d, input logic [7:0] v,
                        input bit ce, input bit rst, output bit accepted);
        ent_t e;
        reset     = rst;
        wr_valid  = wv;
        wr_dst    = d;
        wr_data   = v;
        commit_en = ce;
        accepted  = 1'b0;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        end else begin
            accepted = wv && (mq.size() != DEPTH);
            if (ce && mq.size() != 0) begin
                e = mq.pop_front();
                mregs[e.dst] = e.data;
            end
            if (accepted) begin
                e.dst  = d;
                e.data = v;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        wr_valid  = 1'b0;
        commit_en = 1'b0;
    endtask

    task automatic set_rd(input logic [1:0] a1, input logic [1:0] a2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
    endtask

    // Newest queued write to the index wins, otherwise the committed register.
    task automatic model_read(input logic [1:0] a, output logic [7:0] d, output bit f);
        d = mregs[a];
        f = 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dst == a) begin
                d = mq[i].data;
                f = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit acc;
        step(1'b1, 2'd1, 8'hAA, 1'b0, 1'b0, acc);
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        set_rd(2'd1, 2'd0);
        total++;
        if (rd_data1 !== 8'hAA || rd_fwd1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_precommit rd_data1=%h fwd=%b want AA fwd 0", rd_data1, rd_fwd1);
        end
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, acc);
        set_rd(2'd1, 2'd3);
        total++;
        if (rd_data1 !== 8'h00 || pending !== 2'd0 || wr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_clear rd_data1=%h pending=%0d wr_ready=%b want 00 0 1",
                     rd_data1, pending, wr_ready);
        end
    endtask

    task automatic test_forward_commit();
        bit acc;
        step(1'b1, 2'd2, 8'h5C, 1'b0, 1'b0, acc);
        set_rd(2'd2, 2'd1);
        total++;
        if (rd_data1 !== 8'h5C || rd_fwd1 !== 1'b1 || pending !== 2'd1) begin
            bad++;
            $display("[TB] FAIL fwd_before_commit data=%h fwd=%b pending=%0d want 5C 1 1",
                     rd_data1, rd_fwd1, pending);
        end
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        total++;
        if (rd_data1 !== 8'h5C || rd_fwd1 !== 1'b0 || pending !== 2'd0) begin
            bad++;
            $display("[TB] FAIL fwd_after_commit data=%h fwd=%b pending=%0d want 5C 0 0",
                     rd_data1, rd_fwd1, pending);
        end
    endtask

    task automatic test_full_backpressure();
        bit acc;
        step(1'b1, 2'd0, 8'h11, 1'b0, 1'b0, acc);
        step(1'b1, 2'd1, 8'h22, 1'b0, 1'b0, acc);
        total++;
        if (pending !== 2'd2 || wr_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_state pending=%0d wr_ready=%b want 2 0", pending, wr_ready);
        end
        step(1'b1, 2'd2, 8'h33, 1'b0, 1'b0, acc);
        step(1'b1, 2'd2, 8'h33, 1'b0, 1'b0, acc);
        set_rd(2'd2, 2'd0);
        total++;
        if (pending !== 2'd2 || rd_fwd1 !== 1'b0 || rd_data2 !== 8'h11 || rd_fwd2 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_hold pending=%0d fwd1=%b data2=%h fwd2=%b want 2 0 11 1",
                     pending, rd_fwd1, rd_data2, rd_fwd2);
        end
        step(1'b1, 2'd2, 8'h33, 1'b1, 1'b0, acc);
        total++;
        if (pending !== 2'd1 || rd_data2 !== 8'h11 || rd_fwd2 !== 1'b0 || rd_fwd1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_pop_refuse pending=%0d data2=%h fwd2=%b fwd1=%b want 1 11 0 0",
                     pending, rd_data2, rd_fwd2, rd_fwd1);
        end
        step(1'b1, 2'd2, 8'h33, 1'b0, 1'b0, acc);
        total++;
        if (pending !== 2'd2 || rd_data1 !== 8'h33 || rd_fwd1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_late_accept pending=%0d data1=%h fwd1=%b want 2 33 1",
                     pending, rd_data1, rd_fwd1);
        end
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        set_rd(2'd1, 2'd2);
        total++;
        if (pending !== 2'd0 || rd_data1 !== 8'h22 || rd_data2 !== 8'h33 || rd_fwd2 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_drain pending=%0d r1=%h r2=%h fwd2=%b want 0 22 33 0",
                     pending, rd_data1, rd_data2, rd_fwd2);
        end
    endtask

    task automatic test_push_pop();
        bit acc;
        step(1'b1, 2'd0, 8'hAB, 1'b0, 1'b0, acc);
        step(1'b1, 2'd1, 8'hCD, 1'b1, 1'b0, acc);
        set_rd(2'd0, 2'd1);
        total++;
        if (pending !== 2'd1 || rd_data1 !== 8'hAB || rd_fwd1 !== 1'b0 ||
            rd_data2 !== 8'hCD || rd_fwd2 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL push_pop pending=%0d r0=%h/%b r1=%h/%b want 1 AB/0 CD/1",
                     pending, rd_data1, rd_fwd1, rd_data2, rd_fwd2);
        end
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
    endtask

    task automatic test_same_dst();
        bit acc;
        step(1'b1, 2'd3, 8'h01, 1'b0, 1'b0, acc);
        step(1'b1, 2'd3, 8'h02, 1'b0, 1'b0, acc);
        set_rd(2'd3, 2'd3);
        total++;
        if (rd_data1 !== 8'h02 || rd_fwd1 !== 1'b1 || rd_data2 !== 8'h02) begin
            bad++;
            $display("[TB] FAIL same_dst_both data=%h fwd=%b data2=%h want 02 1 02",
                     rd_data1, rd_fwd1, rd_data2);
        end
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        total++;
        if (rd_data1 !== 8'h02 || rd_fwd1 !== 1'b1 || pending !== 2'd1) begin
            bad++;
            $display("[TB] FAIL same_dst_one data=%h fwd=%b pending=%0d want 02 1 1",
                     rd_data1, rd_fwd1, pending);
        end
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        total++;
        if (rd_data1 !== 8'h02 || rd_fwd1 !== 1'b0 || pending !== 2'd0) begin
            bad++;
            $display("[TB] FAIL same_dst_two data=%h fwd=%b pending=%0d want 02 0 0",
                     rd_data1, rd_fwd1, pending);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        step(1'b1, 2'd0, 8'h77, 1'b0, 1'b0, acc);
        step(1'b1, 2'd2, 8'h88, 1'b0, 1'b0, acc);
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, acc);
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, acc);
        for (int a = 0; a < 4; a++) begin
            set_rd(2'(a), 2'(3 - a));
            total++;
            if (rd_data1 !== 8'h00 || rd_data2 !== 8'h00 || rd_fwd1 !== 1'b0 ||
                rd_fwd2 !== 1'b0 || pending !== 2'd0) begin
                bad++;
                $display("[TB] FAIL reset_mid addr=%0d d1=%h d2=%h fwd=%b%b pending=%0d want 00 00 00 0",
                         a, rd_data1, rd_data2, rd_fwd1, rd_fwd2, pending);
            end
        end
    endtask

    task automatic test_random();
        bit         acc;
        bit         hold = 1'b0;
        bit         wv;
        bit         ce;
        bit         rst;
        logic [1:0] d;
        logic [7:0] v;
        logic [7:0] md1;
        logic [7:0] md2;
        bit         mf1;
        bit         mf2;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                wv = ($urandom_range(0, 9) < 6);
                d  = 2'($urandom_range(0, 3));
                v  = 8'($urandom);
            end
            ce  = ($urandom_range(0, 9) < 5);
            rst = ($urandom_range(0, 59) == 0);
            step(wv, d, v, ce, rst, acc);
            hold = wv && !acc && !rst;
            set_rd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            model_read(rd_addr1, md1, mf1);
            model_read(rd_addr2, md2, mf2);
            total++;
            if (rd_data1 !== md1 || rd_fwd1 !== mf1 || rd_data2 !== md2 || rd_fwd2 !== mf2 ||
                pending !== 2'(mq.size()) || wr_ready !== (mq.size() != DEPTH)) begin
                bad++;
                $display("[TB] FAIL random c=%0d got d1=%h/%b d2=%h/%b p=%0d rdy=%b want d1=%h/%b d2=%h/%b p=%0d",
                         c, rd_data1, rd_fwd1, rd_data2, rd_fwd2, pending, wr_ready,
                         md1, mf1, md2, mf2, mq.size());
            end
        end
    endtask

    initial begin
        bit acc;
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, acc);
        test_reset();
        test_forward_commit();
        test_full_backpressure();
        test_push_pop();
        test_same_dst();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
